pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; generalises the plain PC load register.
//  Each enabled cycle it computes the next instruction address: hold, increment, jump,
//  conditional relative branch, call or return. Calls and returns use a hardware
//  return-address stack.
//  Sits between the decode stage and the instruction memory address port.
// PARAMETERS
//  PC_BITS         8    width of PC, target and offset buses
//  INST_MEM_DEPTH  128  instruction words; power of 2, <= 2**PC_BITS
//  STACK_DEPTH     4    return-address stack entries (>=1)
//  RESET_ADDR      0    PC value after reset; must be < INST_MEM_DEPTH
// PORTS
//  i_clk        in   1                   clock, rising edge
//  i_nrst       in   1                   reset, asynchronous, active-low
//  i_en         in   1                   1 = execute i_op this edge; 0 = freeze all state
//  i_op         in   3                   0 HOLD,1 INC,2 JUMP,3 BRANCH,4 CALL,5 RET,6-7 illegal
//  i_target     in   PC_BITS             JUMP/CALL absolute address; BRANCH signed offset
//  i_cond       in   1                   BRANCH taken when 1
//  o_pc         out  PC_BITS             current instruction address (registered)
//  o_valid      out  1                   o_pc is a valid fetch address
//  o_sp         out  $clog2(STACK_DEPTH+1)  stack entries in use
//  o_err        out  1                   sticky error flag
//  o_err_code   out  2                   first error: 1 stack overflow, 2 underflow, 3 bad jump/op
// BEHAVIOUR
//  Reset (async): o_pc=RESET_ADDR, o_valid=0, o_sp=0, o_err=0, o_err_code=0; stack cleared.
//  First rising edge after i_nrst deasserts: o_valid<=1 only; i_op ignored on that edge.
//  Afterwards, every rising edge with i_en=1 applies i_op; result visible on o_pc after
//    that edge (1-cycle latency, no combinational path from inputs to o_pc).
//  i_en=0: PC, stack, SP and error state all hold.
//  Arithmetic modulo INST_MEM_DEPTH (mask to log2 bits); upper PC bits always 0.
//  HOLD:   pc unchanged.
//  INC:    pc <= pc+1; DEPTH-1 wraps to 0.
//  JUMP:   i_target < DEPTH -> pc <= i_target; else pc holds, error code 3.
//  BRANCH: i_cond=1 -> pc <= pc + signed(i_target), wraps both directions;
//          i_cond=0 -> pc <= pc+1.
//  CALL:   sp < STACK_DEPTH and i_target < DEPTH -> stack[sp] <= pc+1 (wrapped), sp++,
//            pc <= i_target.
//          Stack full -> no push, pc holds, error code 1 (checked before target range).
//          Stack not full and i_target out of range -> no push, pc holds, error code 3.
//  RET:    sp > 0 -> pc <= stack[sp-1], sp--; sp==0 -> pc holds, error code 2.
//  Illegal op 6/7: pc holds, error code 3.
//  Errors: o_err sets on the edge the fault is applied and stays set until reset.
//    o_err_code latches the first fault only; later faults do not change it.
//    Operation continues normally after an error.
//  Reset mid-operation: immediate async clear, including stack contents and error state.
// TESTING
//  Reset, release, 3 edges INC (i_en=1) -> o_valid=1 after edge 1; o_pc 0,1,2 after edges 1,2,3.
//  PC=127, INC -> o_pc=0; PC=2, BRANCH i_cond=1 i_target=8'hFC -> o_pc=126.
//  JUMP 8'd200 (DEPTH 128) -> o_pc unchanged, o_err=1, o_err_code=3.
//  CALL 10,20,30,40 from PC=5 -> o_sp=4; 5th CALL -> o_err_code=1, pc holds.
//  Then 4 RET -> o_pc 31,21,11,6, o_sp=0; 5th RET -> pc holds, o_err_code stays 1.
//  i_en=0 with op INC for 5 cycles -> o_pc constant.
//  Assert i_nrst=0 mid-CALL sequence -> o_pc=0, o_sp=0, o_err=0 immediately, no clock needed.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold/inc/jump/branch/call/ret.
// Calls and returns share a small hardware return-address stack.
module pc_sequencer #(
  parameter int PC_BITS        = 8,
  parameter int INST_MEM_DEPTH = 128,
  parameter int STACK_DEPTH    = 4,
  parameter int RESET_ADDR     = 0,
  localparam int SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_en,
  input  logic [2:0]         i_op,
  input  logic [PC_BITS-1:0] i_target,
  input  logic               i_cond,
  output logic [PC_BITS-1:0] o_pc,
  output logic               o_valid,
  output logic [SPW-1:0]     o_sp,
  output logic               o_err,
  output logic [1:0]         o_err_code
);

  localparam int IW =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [PC_BITS-1:0] MASK =
    PC_BITS'(INST_MEM_DEPTH - 1);

  localparam logic [PC_BITS:0] DEPTH_X =
    (PC_BITS + 1)'(INST_MEM_DEPTH);

  localparam logic [SPW-1:0] SP_FULL =
    SPW'(STACK_DEPTH);

  localparam logic [PC_BITS-1:0] RST_PC =
    PC_BITS'(RESET_ADDR);

  localparam logic [1:0] E_OVF = 2'd1;
  localparam logic [1:0] E_UNF = 2'd2;
  localparam logic [1:0] E_BAD = 2'd3;

  logic [PC_BITS-1:0] stack [STACK_DEPTH];

  logic [PC_BITS-1:0] pc_inc;
  logic [PC_BITS-1:0] br_pc;
  logic               tgt_ok;
  logic               full;
  logic               empty;
  logic [IW-1:0]      wr_idx;
  logic [IW-1:0]      rd_idx;

  logic op_hold;
  logic op_inc;
  logic op_jump;
  logic op_br;
  logic op_call;
  logic op_ret;
  logic op_bad;

  logic [PC_BITS-1:0] nxt_pc;
  logic               push;
  logic               pop;
  logic               fault;
  logic [1:0]         fcode;

  assign pc_inc = (o_pc + PC_BITS'(1)) & MASK;
  assign br_pc  = (o_pc + i_target) & MASK;
  assign tgt_ok = {1'b0, i_target} < DEPTH_X;
  assign full   = (o_sp >= SP_FULL);
  assign empty  = (o_sp == '0);
  assign wr_idx = IW'(o_sp);
  assign rd_idx = IW'(o_sp - SPW'(1));

  assign op_hold = (i_op == 3'd0);
  assign op_inc  = (i_op == 3'd1);
  assign op_jump = (i_op == 3'd2);
  assign op_br   = (i_op == 3'd3);
  assign op_call = (i_op == 3'd4);
  assign op_ret  = (i_op == 3'd5);
  assign op_bad  = i_op[2] & i_op[1];

  // Decode the op into next pc, stack action and fault.
  always_comb begin
    nxt_pc = o_pc;
    push   = 1'b0;
    pop    = 1'b0;
    fault  = 1'b0;
    fcode  = 2'd0;
    unique case (1'b1)
      op_hold: nxt_pc = o_pc;
      op_inc:  nxt_pc = pc_inc;
      op_jump: begin
        if (tgt_ok) begin
          nxt_pc = i_target;
        end else begin
          fault = 1'b1;
          fcode = E_BAD;
        end
      end
      op_br:   nxt_pc = i_cond ? br_pc : pc_inc;
      op_call: begin
        if (full) begin
          fault = 1'b1;
          fcode = E_OVF;
        end else if (!tgt_ok) begin
          fault = 1'b1;
          fcode = E_BAD;
        end else begin
          push   = 1'b1;
          nxt_pc = i_target;
        end
      end
      op_ret:  begin
        if (empty) begin
          fault = 1'b1;
          fcode = E_UNF;
        end else begin
          pop    = 1'b1;
          nxt_pc = stack[rd_idx];
        end
      end
      op_bad:  begin
        fault = 1'b1;
        fcode = E_BAD;
      end
      default: nxt_pc = o_pc;
    endcase
  end

  // State update; first edge after reset only raises o_valid.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_pc       <= RST_PC;
      o_valid    <= 1'b0;
      o_sp       <= '0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (!o_valid) begin
      o_valid <= 1'b1;
    end else if (i_en) begin
      o_pc <= nxt_pc;
      if (push) begin
        stack[wr_idx] <= pc_inc;
        o_sp          <= o_sp + SPW'(1);
      end
      if (pop) begin
        o_sp <= o_sp - SPW'(1);
      end
      if (fault) begin
        o_err <= 1'b1;
        if (!o_err) begin
          o_err_code <= fcode;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed cases plus random ops
// checked against a queue-based reference model.
module tb_pc_sequencer;

  localparam int DEPTH = 128;
  localparam int SDEP  = 4;

  logic       clk;
  logic       nrst;
  logic       en;
  logic [2:0] op;
  logic [7:0] tgt;
  logic       cond;
  logic [7:0] pc;
  logic       valid;
  logic [2:0] sp;
  logic       err;
  logic [1:0] code;

  int total = 0;
  int bad   = 0;

  int m_pc;
  int m_valid;
  int m_err;
  int m_code;
  int m_stk[$];

  pc_sequencer #(
    .PC_BITS(8),
    .INST_MEM_DEPTH(DEPTH),
    .STACK_DEPTH(SDEP),
    .RESET_ADDR(0)
  ) dut (
    .i_clk(clk),
    .i_nrst(nrst),
    .i_en(en),
    .i_op(op),
    .i_target(tgt),
    .i_cond(cond),
    .o_pc(pc),
    .o_valid(valid),
    .o_sp(sp),
    .o_err(err),
    .o_err_code(code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc    = 0;
    m_valid = 0;
    m_err   = 0;
    m_code  = 0;
    m_stk.delete();
  endtask

  task automatic m_fault(input int c);
    if (m_err == 0) m_code = c;
    m_err = 1;
  endtask

  task automatic m_step(input int e, input int o,
                        input int t, input int c);
    int off;
    if (m_valid == 0) begin
      m_valid = 1;
      return;
    end
    if (e == 0) return;
    case (o)
      0: ;
      1: m_pc = (m_pc + 1) % DEPTH;
      2: if (t < DEPTH) m_pc = t;
         else m_fault(3);
      3: begin
        off = (t >= 128) ? t - 256 : t;
        if (c != 0) m_pc = (m_pc + off + 256) % DEPTH;
        else m_pc = (m_pc + 1) % DEPTH;
      end
      4: begin
        if (m_stk.size() >= SDEP) m_fault(1);
        else if (t >= DEPTH) m_fault(3);
        else begin
          m_stk.push_back((m_pc + 1) % DEPTH);
          m_pc = t;
        end
      end
      5: begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_fault(2);
      end
      default: m_fault(3);
    endcase
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},    32'(pc),    32'(m_pc));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".sp"},    32'(sp),    32'(m_stk.size()));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".code"},  32'(code),  32'(m_code));
  endtask

  // Drive inputs, take one edge, advance model, compare.
  task automatic cyc(input string tag, input int e,
                     input int o, input int t, input int c);
    en   = e[0];
    op   = o[2:0];
    tgt  = t[7:0];
    cond = c[0];
    @(posedge clk);
    m_step(e, o, t, c);
    #1;
    chk_all(tag);
  endtask

  // Async reset between edges, then release before next edge.
  task automatic async_reset(input string tag);
    #2;
    nrst = 1'b0;
    m_reset();
    #1;
    chk_all(tag);
    #2;
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    en   = 1'b0;
    op   = 3'd0;
    tgt  = 8'd0;
    cond = 1'b0;
    m_reset();
    #12;
    chk_all("reset");
    nrst = 1'b1;

    cyc("inc1", 1, 1, 0, 0);
    chk("inc1_pc0", 32'(pc), 0);
    chk("inc1_valid", 32'(valid), 1);
    cyc("inc2", 1, 1, 0, 0);
    chk("inc2_pc1", 32'(pc), 1);
    cyc("inc3", 1, 1, 0, 0);
    chk("inc3_pc2", 32'(pc), 2);

    cyc("j127", 1, 2, 127, 0);
    cyc("wrap", 1, 1, 0, 0);
    chk("wrap_pc0", 32'(pc), 0);
    cyc("j2", 1, 2, 2, 0);
    cyc("brback", 1, 3, 8'hFC, 1);
    chk("brback_pc126", 32'(pc), 126);
    cyc("brnt", 1, 3, 8'h10, 0);
    chk("brnt_pc127", 32'(pc), 127);

    cyc("jbad", 1, 2, 200, 0);
    chk("jbad_pc", 32'(pc), 127);
    chk("jbad_code", 32'(code), 3);

    async_reset("rst2");
    cyc("rel2", 1, 1, 0, 0);
    cyc("j5", 1, 2, 5, 0);
    cyc("call10", 1, 4, 10, 0);
    cyc("call20", 1, 4, 20, 0);
    cyc("call30", 1, 4, 30, 0);
    cyc("call40", 1, 4, 40, 0);
    chk("sp4", 32'(sp), 4);
    cyc("call5", 1, 4, 50, 0);
    chk("ovf_code", 32'(code), 1);
    chk("ovf_pc", 32'(pc), 40);
    cyc("ret1", 1, 5, 0, 0);
    chk("ret1_pc", 32'(pc), 31);
    cyc("ret2", 1, 5, 0, 0);
    chk("ret2_pc", 32'(pc), 21);
    cyc("ret3", 1, 5, 0, 0);
    chk("ret3_pc", 32'(pc), 11);
    cyc("ret4", 1, 5, 0, 0);
    chk("ret4_pc", 32'(pc), 6);
    chk("ret4_sp", 32'(sp), 0);
    cyc("ret5", 1, 5, 0, 0);
    chk("unf_pc", 32'(pc), 6);
    chk("unf_code", 32'(code), 1);

    for (int i = 0; i < 5; i++) begin
      cyc("frz", 0, 1, 0, 0);
      chk("frz_pc", 32'(pc), 6);
    end

    cyc("ill6", 1, 6, 0, 0);
    cyc("call_oor", 1, 4, 130, 0);

    async_reset("rst3");
    cyc("rel3", 1, 0, 0, 0);
    cyc("mc1", 1, 4, 50, 0);
    cyc("mc2", 1, 4, 60, 0);
    cyc("mc3", 1, 2, 200, 0);
    async_reset("rst_mid");
    chk("mid_pc", 32'(pc), 0);
    chk("mid_sp", 32'(sp), 0);
    chk("mid_err", 32'(err), 0);
    cyc("rel4", 1, 1, 0, 0);
    cyc("rel4b", 1, 5, 0, 0);
    chk("rel4b_code", 32'(code), 2);

    for (int i = 0; i < 400; i++) begin
      int e;
      int o;
      int t;
      if (i % 100 == 99) begin
        async_reset("rnd_rst");
      end
      e = ($urandom_range(0, 7) != 0) ? 1 : 0;
      o = $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) o = $urandom_range(6, 7);
      t = ($urandom_range(0, 7) == 0) ?
          $urandom_range(128, 255) : $urandom_range(0, 127);
      if (o == 3 && $urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, 255);
      end
      cyc("rnd", e, o, t, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
